// File: rtl/image_mem_ctrl_if.sv
// Bus bundle between an image memory controller and its two requesters:
// a CPU issuing single-word accesses and an external engine issuing bursts.
interface image_mem_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [LEN_W-1:0]  ext_len;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_ack;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_rvalid;
   logic              ext_done;

   logic              busy;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
      input  cpu_rdata, cpu_ack,
      input  ext_ack, ext_rdata, ext_rvalid, ext_done,
      input  busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
      output cpu_rdata, cpu_ack,
      output ext_ack, ext_rdata, ext_rvalid, ext_done,
      output busy
   );
endinterface

// File: rtl/image_mem_ctrl.sv
// Image memory controller: a single-port synchronous-read word memory shared
// between CPU single-word accesses and external bursts, with round-robin or
// CPU-priority arbitration. Bursts wrap from DEPTH-1 to 0; accesses at or
// above DEPTH are acknowledged but write nothing and read back zero.
module image_mem_ctrl #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 65536,
   parameter int LEN_W    = 4,
   parameter int ARB_MODE = 0
) (
   input logic             main_clock,
   input logic             reset,
   image_mem_ctrl_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      CPU_ACC,
      EXT_BURST,
      EXT_LAST
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_ext;
   logic              grant_cpu;
   logic              grant_ext;

   logic [ADDR_W-1:0] beat_addr;
   logic [LEN_W-1:0]  beat_cnt;
   logic [LEN_W-1:0]  burst_len;
   logic              burst_we;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] mem_addr;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              in_range;
   logic [DATA_W-1:0] rd_word;
   logic              cpu_rd;
   logic              ext_rd;

   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] ext_rdata_q;
   logic              ext_rvalid_q;

   // Arbitration in IDLE and next-state selection; a burst runs until its
   // beat counter reaches the latched length, then spends one cycle in EXT_LAST.
   always_comb begin
      state_nxt = state;
      grant_cpu = 1'b0;
      grant_ext = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cpu_req && bus.ext_req) begin
               if (ARB_MODE == 1 || last_ext) begin
                  grant_cpu = 1'b1;
               end else begin
                  grant_ext = 1'b1;
               end
            end else if (bus.cpu_req) begin
               grant_cpu = 1'b1;
            end else if (bus.ext_req) begin
               grant_ext = 1'b1;
            end
            if (grant_cpu) begin
               state_nxt = CPU_ACC;
            end else if (grant_ext) begin
               state_nxt = EXT_BURST;
            end
         end
         CPU_ACC: begin
            state_nxt = IDLE;
         end
         EXT_BURST: begin
            if (beat_cnt == burst_len) begin
               state_nxt = EXT_LAST;
            end
         end
         EXT_LAST: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Single memory port: the CPU uses it on its grant edge, a burst uses it
   // once per EXT_BURST cycle; out-of-range addresses never touch the array.
   always_comb begin
      mem_addr  = beat_addr;
      mem_wdata = bus.ext_wdata;
      mem_we    = 1'b0;
      cpu_rd    = 1'b0;
      ext_rd    = 1'b0;
      if (grant_cpu) begin
         mem_addr  = bus.cpu_addr;
         mem_wdata = bus.cpu_wdata;
         mem_we    = bus.cpu_we;
         cpu_rd    = ~bus.cpu_we;
      end else if (state == EXT_BURST) begin
         mem_we = burst_we;
         ext_rd = ~burst_we;
      end
      in_range = ({1'b0, mem_addr} < DEPTH_V);
      mem_idx  = mem_addr[IDX_W-1:0];
      rd_word  = in_range ? mem[mem_idx] : '0;
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge main_clock) begin
      if (mem_we && in_range) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   // State register and round-robin pointer; after reset the pointer
   // behaves as if the external side was served last, so the CPU wins first.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last_ext <= 1'b1;
      end else begin
         state <= state_nxt;
         if (grant_cpu) begin
            last_ext <= 1'b0;
         end else if (grant_ext) begin
            last_ext <= 1'b1;
         end
      end
   end

   // Burst bookkeeping: latch the request on grant, then step address and
   // beat count once per issued beat, wrapping the address at DEPTH-1.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         beat_addr <= '0;
         beat_cnt  <= '0;
         burst_len <= '0;
         burst_we  <= 1'b0;
      end else if (grant_ext) begin
         beat_addr <= bus.ext_addr;
         beat_cnt  <= '0;
         burst_len <= bus.ext_len;
         burst_we  <= bus.ext_we;
      end else if (state == EXT_BURST) begin
         beat_addr <= (beat_addr == LAST_ADDR) ? '0 : beat_addr + 1'b1;
         beat_cnt  <= beat_cnt + 1'b1;
      end
   end

   // Registered read data and the read-beat strobe, one cycle behind issue;
   // the data registers only change when a matching read is performed.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         cpu_rdata_q  <= '0;
         ext_rdata_q  <= '0;
         ext_rvalid_q <= 1'b0;
      end else begin
         ext_rvalid_q <= ext_rd;
         if (cpu_rd) begin
            cpu_rdata_q <= rd_word;
         end
         if (ext_rd) begin
            ext_rdata_q <= rd_word;
         end
      end
   end

   assign bus.cpu_ack    = (state == CPU_ACC);
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.ext_ack    = (state == EXT_BURST) && burst_we;
   assign bus.ext_rdata  = ext_rdata_q;
   assign bus.ext_rvalid = ext_rvalid_q;
   assign bus.ext_done   = (state == EXT_LAST);
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_image_mem_ctrl.sv
// Self-checking bench for image_mem_ctrl: a round-robin instance and a
// CPU-priority instance share identical stimulus; a word-array model with
// the wrap and out-of-range rules predicts every beat and every read.
module tb_image_mem_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 256;
   localparam int LEN_W  = 4;

   logic main_clock = 1'b0;
   logic reset;

   int check_count = 0;
   int error_count = 0;

   logic [DATA_W-1:0] ref_mem [DEPTH];

   image_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_rr ();
   image_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_fp ();

   image_mem_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .ARB_MODE(0)
   ) dut_rr (
      .main_clock(main_clock),
      .reset(reset),
      .bus(bus_rr.slave)
   );

   image_mem_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .ARB_MODE(1)
   ) dut_fp (
      .main_clock(main_clock),
      .reset(reset),
      .bus(bus_fp.slave)
   );

   assign bus_fp.cpu_req   = bus_rr.cpu_req;
   assign bus_fp.cpu_we    = bus_rr.cpu_we;
   assign bus_fp.cpu_addr  = bus_rr.cpu_addr;
   assign bus_fp.cpu_wdata = bus_rr.cpu_wdata;
   assign bus_fp.ext_req   = bus_rr.ext_req;
   assign bus_fp.ext_we    = bus_rr.ext_we;
   assign bus_fp.ext_addr  = bus_rr.ext_addr;
   assign bus_fp.ext_len   = bus_rr.ext_len;
   assign bus_fp.ext_wdata = bus_rr.ext_wdata;

   // 10 ns clock
   always #5 main_clock = ~main_clock;

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", check_count, error_count);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: next burst address, wrapping only from DEPTH-1 to 0
   function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] a);
      int n;
      n = (int'(a) == DEPTH - 1) ? 0 : (int'(a) + 1) % 65536;
      return ADDR_W'(n);
   endfunction

   function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
      if (int'(a) < DEPTH) return ref_mem[int'(a)];
      return '0;
   endfunction

   task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
   endtask

   task automatic drive_idle();
      bus_rr.cpu_req   = 1'b0;
      bus_rr.cpu_we    = 1'b0;
      bus_rr.cpu_addr  = '0;
      bus_rr.cpu_wdata = '0;
      bus_rr.ext_req   = 1'b0;
      bus_rr.ext_we    = 1'b0;
      bus_rr.ext_addr  = '0;
      bus_rr.ext_len   = '0;
      bus_rr.ext_wdata = '0;
   endtask

   task automatic pulse_reset();
      @(posedge main_clock); #1;
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge main_clock);
      #3 reset = 1'b0;
   endtask

   // One CPU access; ack must appear in the second sampled cycle after the request
   task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      int lat;
      logic [DATA_W-1:0] got;
      lat = 0;
      got = '0;
      @(posedge main_clock); #1;
      bus_rr.cpu_req   = 1'b1;
      bus_rr.cpu_we    = we;
      bus_rr.cpu_addr  = addr;
      bus_rr.cpu_wdata = wdata;
      for (int i = 1; i <= 10; i++) begin
         @(negedge main_clock);
         if (bus_rr.cpu_ack) begin
            lat = i;
            got = bus_rr.cpu_rdata;
            break;
         end
      end
      checkOutput("cpu_ack_latency", lat, 2);
      if (we) begin
         model_write(addr, wdata);
      end else begin
         checkOutput($sformatf("cpu_rdata@%0h", addr), got, model_read(addr));
      end
      @(posedge main_clock); #1;
      bus_rr.cpu_req  = 1'b0;
      bus_rr.cpu_addr = ADDR_W'($urandom);
   endtask

   // One external burst; beat timing, beat count, done position and read data
   task automatic ext_burst(input logic we, input logic [ADDR_W-1:0] addr, input int len, input logic [DATA_W-1:0] wd [16]);
      logic [DATA_W-1:0] exp_rd [16];
      logic [ADDR_W-1:0] a;
      int ack_n, rv_n, first_ack, last_ack, first_rv, last_rv, done_idx;
      ack_n = 0; rv_n = 0; first_ack = 0; last_ack = 0;
      first_rv = 0; last_rv = 0; done_idx = 0;
      a = addr;
      for (int k = 0; k <= len; k++) begin
         exp_rd[k] = model_read(a);
         a = model_next(a);
      end
      @(posedge main_clock); #1;
      bus_rr.ext_req   = 1'b1;
      bus_rr.ext_we    = we;
      bus_rr.ext_addr  = addr;
      bus_rr.ext_len   = LEN_W'(len);
      bus_rr.ext_wdata = we ? wd[0] : DATA_W'($urandom);
      for (int i = 1; i <= 40; i++) begin
         @(negedge main_clock);
         if (bus_rr.ext_ack) begin
            if (ack_n == 0) first_ack = i;
            last_ack = i;
            ack_n++;
         end
         if (bus_rr.ext_rvalid) begin
            if (rv_n == 0) first_rv = i;
            last_rv = i;
            if (rv_n <= len) checkOutput($sformatf("ext_rdata beat%0d", rv_n), bus_rr.ext_rdata, exp_rd[rv_n]);
            rv_n++;
         end
         if (bus_rr.ext_done) begin
            done_idx = i;
            break;
         end
         @(posedge main_clock); #1;
         bus_rr.ext_addr  = ADDR_W'($urandom);
         bus_rr.ext_wdata = we ? wd[ack_n % 16] : DATA_W'($urandom);
      end
      @(posedge main_clock); #1;
      bus_rr.ext_req = 1'b0;
      checkOutput("ext_done_index", done_idx, len + 3);
      if (we) begin
         checkOutput("ext_ack_count", ack_n, len + 1);
         checkOutput("ext_ack_first", first_ack, 2);
         checkOutput("ext_ack_last", last_ack, len + 2);
         checkOutput("ext_rvalid_on_write", rv_n, 0);
         a = addr;
         for (int k = 0; k <= len; k++) begin
            model_write(a, wd[k]);
            a = model_next(a);
         end
      end else begin
         checkOutput("ext_rvalid_count", rv_n, len + 1);
         checkOutput("ext_rvalid_first", first_rv, 3);
         checkOutput("ext_rvalid_last", last_rv, len + 3);
         checkOutput("ext_ack_on_read", ack_n, 0);
      end
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return ADDR_W'($urandom_range(0, DEPTH - 1));
      if (r == 7) return ADDR_W'($urandom_range(DEPTH - 16, DEPTH - 1));
      if (r == 8) return ADDR_W'($urandom_range(DEPTH, DEPTH + 15));
      return ADDR_W'($urandom_range(65528, 65535));
   endfunction

   // One random transaction from either requester
   task automatic applyStimulus();
      logic [DATA_W-1:0] wd [16];
      for (int k = 0; k < 16; k++) wd[k] = DATA_W'($urandom);
      if ($urandom_range(0, 1) == 0) begin
         cpu_access(1'($urandom_range(0, 1)), rand_addr(), DATA_W'($urandom));
      end else begin
         ext_burst(1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 15), wd);
      end
   endtask

   // Reset during the second beat of an 8-beat write burst
   task automatic reset_mid_burst();
      logic [DATA_W-1:0] wd [16];
      int seen, done_seen;
      seen = 0;
      done_seen = 0;
      for (int k = 0; k < 16; k++) wd[k] = DATA_W'($urandom);
      @(posedge main_clock); #1;
      bus_rr.ext_req   = 1'b1;
      bus_rr.ext_we    = 1'b1;
      bus_rr.ext_addr  = 16'h0030;
      bus_rr.ext_len   = LEN_W'(7);
      bus_rr.ext_wdata = wd[0];
      for (int i = 1; i <= 10; i++) begin
         @(negedge main_clock);
         if (bus_rr.ext_ack) begin
            seen = 1;
            break;
         end
      end
      checkOutput("rst_first_beat_seen", seen, 1);
      @(posedge main_clock); #1;
      bus_rr.ext_wdata = wd[1];
      #2;
      reset = 1'b1;
      bus_rr.ext_req = 1'b0;
      #1;
      checkOutput("rst_busy", bus_rr.busy, 0);
      checkOutput("rst_ext_ack", bus_rr.ext_ack, 0);
      checkOutput("rst_ext_rvalid", bus_rr.ext_rvalid, 0);
      checkOutput("rst_ext_done", bus_rr.ext_done, 0);
      checkOutput("rst_cpu_ack", bus_rr.cpu_ack, 0);
      checkOutput("rst_ext_rdata", bus_rr.ext_rdata, 0);
      checkOutput("rst_cpu_rdata", bus_rr.cpu_rdata, 0);
      repeat (2) @(posedge main_clock);
      #3 reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge main_clock);
         if (bus_rr.ext_done || bus_rr.ext_ack || bus_rr.busy) done_seen++;
      end
      checkOutput("rst_no_further_activity", done_seen, 0);
      model_write(16'h0030, wd[0]);
      cpu_access(1'b0, 16'h0030, 8'h00);
      cpu_access(1'b0, 16'h0031, 8'h00);
   endtask

   // Both requesters held high from a fresh reset
   task automatic arb_test();
      int ev_rr[$];
      int fp_cpu, fp_ext;
      fp_cpu = 0;
      fp_ext = 0;
      pulse_reset();
      @(posedge main_clock); #1;
      bus_rr.cpu_req  = 1'b1;
      bus_rr.cpu_we   = 1'b0;
      bus_rr.cpu_addr = 16'h0010;
      bus_rr.ext_req  = 1'b1;
      bus_rr.ext_we   = 1'b0;
      bus_rr.ext_addr = 16'h0020;
      bus_rr.ext_len  = LEN_W'(1);
      for (int i = 0; i < 24; i++) begin
         @(negedge main_clock);
         if (bus_rr.cpu_ack) ev_rr.push_back(1);
         if (bus_rr.ext_done) ev_rr.push_back(2);
         if (bus_fp.cpu_ack) fp_cpu++;
         if (bus_fp.ext_done || bus_fp.ext_rvalid) fp_ext++;
      end
      checkOutput("arb_rr_events_ge4", ev_rr.size() >= 4, 1);
      for (int k = 0; k < 4 && k < ev_rr.size(); k++) begin
         checkOutput($sformatf("arb_rr_order%0d", k), ev_rr[k], (k % 2 == 0) ? 1 : 2);
      end
      checkOutput("arb_fp_cpu_grants_ge4", fp_cpu >= 4, 1);
      checkOutput("arb_fp_ext_starved", fp_ext, 0);
      pulse_reset();
   endtask

   initial begin
      logic [DATA_W-1:0] wd [16];

      reset = 1'b1;
      drive_idle();
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      repeat (2) @(negedge main_clock);
      checkOutput("reset_busy", bus_rr.busy, 0);
      checkOutput("reset_cpu_ack", bus_rr.cpu_ack, 0);
      checkOutput("reset_ext_ack", bus_rr.ext_ack, 0);
      checkOutput("reset_ext_rvalid", bus_rr.ext_rvalid, 0);
      checkOutput("reset_ext_done", bus_rr.ext_done, 0);
      checkOutput("reset_cpu_rdata", bus_rr.cpu_rdata, 0);
      checkOutput("reset_ext_rdata", bus_rr.ext_rdata, 0);
      @(posedge main_clock); #3;
      reset = 1'b0;

      $display("[TB] CPU write/read of 0xA5");
      cpu_access(1'b1, 16'h0010, 8'hA5);
      cpu_access(1'b0, 16'h0010, 8'h00);
      checkOutput("cpu_rdata_hold", bus_rr.cpu_rdata, 8'hA5);

      $display("[TB] preloading memory with write bursts");
      for (int b = 0; b < DEPTH / 16; b++) begin
         for (int k = 0; k < 16; k++) wd[k] = DATA_W'($urandom);
         ext_burst(1'b1, ADDR_W'(b * 16), 15, wd);
      end

      $display("[TB] burst write/read of 1,2,3,4");
      for (int k = 0; k < 16; k++) wd[k] = DATA_W'(k + 1);
      ext_burst(1'b1, 16'h0040, 3, wd);
      ext_burst(1'b0, 16'h0040, 3, wd);
      checkOutput("ext_rdata_hold", bus_rr.ext_rdata, 8'h04);

      $display("[TB] out-of-range burst at 0x0100");
      ext_burst(1'b1, 16'h0100, 3, wd);
      ext_burst(1'b0, 16'h0100, 3, wd);

      $display("[TB] wrap read at DEPTH-1");
      cpu_access(1'b1, 16'h00FF, 8'h3C);
      cpu_access(1'b1, 16'h0000, 8'hC3);
      ext_burst(1'b0, 16'h00FF, 1, wd);

      $display("[TB] random transactions");
      for (int n = 0; n < 40; n++) applyStimulus();

      $display("[TB] reset during burst");
      reset_mid_burst();

      $display("[TB] arbitration");
      arb_test();
      cpu_access(1'b0, 16'h0030, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/image_mem_ctrl.md
IMAGE_MEM_CTRL -- requirements
Module: IMAGE_MEM_CTRL

Interface
REQ-001 Parameters SHALL be: DATA_W 8, word width; ADDR_W 16, address width; DEPTH 65536, number of words (DEPTH ≤ 2^ADDR_W); LEN_W 4, burst-length field width; ARB_MODE 0, 0 = round-robin and 1 = CPU fixed priority.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports as follows.
REQ-003 MAIN_CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 CPU_REQ  in  1  CPU single-word access request; held until CPU_ACK.
REQ-006 CPU_WE  in  1  1 = write, 0 = read; sampled at grant.
REQ-007 CPU_ADDR  in  ADDR_W  CPU word address.
REQ-008 CPU_WDATA  in  DATA_W  CPU write data.
REQ-009 CPU_RDATA  out  DATA_W  CPU read data, valid while CPU_ACK=1.
REQ-010 CPU_ACK  out  1  one-cycle completion pulse.
REQ-011 EXT_REQ  in  1  external burst request; held until EXT_DONE.
REQ-012 EXT_WE  in  1  burst direction, sampled at grant.
REQ-013 EXT_ADDR  in  ADDR_W  burst start address.
REQ-014 EXT_LEN  in  LEN_W  beats minus one (0 = 1 beat, max 2^LEN_W beats).
REQ-015 EXT_WDATA  in  DATA_W  write-beat data, consumed while EXT_ACK=1.
REQ-016 EXT_ACK  out  1  high in each cycle a write beat is stored.
REQ-017 EXT_RDATA  out  DATA_W  read-beat data, valid while EXT_RVALID=1.
REQ-018 EXT_RVALID  out  1  read-beat valid strobe.
REQ-019 EXT_DONE  out  1  one-cycle pulse marking burst completion.
REQ-020 BUSY  out  1  high in any state other than IDLE.

Function
REQ-021 Storage SHALL be an internal DEPTH x DATA_W array with synchronous read (one-cycle latency) and one access per cycle.
REQ-022 The FSM SHALL have states IDLE, CPU_ACC, EXT_BURST and EXT_LAST.
REQ-023 In IDLE with exactly one request pending, that requester SHALL be granted on the next edge; with no request, the FSM stays in IDLE.
REQ-024 When both request in IDLE: ARB_MODE=1 grants the CPU; ARB_MODE=0 grants the requester not granted most recently.
REQ-025 CPU grant: IDLE->CPU_ACC issues the access; in the following cycle CPU_ACK=1 (with CPU_RDATA for reads) and the FSM returns to IDLE; a CPU access takes 2 cycles.
REQ-026 EXT grant SHALL latch address, length and direction, then move to EXT_BURST, issuing one beat per cycle with the address incremented per beat.
REQ-027 The burst address SHALL wrap from DEPTH-1 to 0.
REQ-028 Write burst: EXT_ACK=1 in each cycle a beat is issued, and EXT_WDATA is written in that cycle.
REQ-029 Read burst: EXT_RVALID=1 exactly one cycle after each beat is issued, giving EXT_LEN+1 consecutive RVALID cycles.
REQ-030 After the last beat the FSM SHALL enter EXT_LAST, pulse EXT_DONE there (coincident with the final RVALID for reads), then return to IDLE.
REQ-031 Bursts are non-preemptible; a CPU_REQ arriving mid-burst waits, and in ARB_MODE=0 it wins the next arbitration.
REQ-032 Addresses ≥ DEPTH: writes are dropped while still acked; reads return 0 while still strobed.
REQ-033 Requests that deassert before grant SHALL be ignored; inputs are not checked after grant except EXT_WDATA.
REQ-034 CPU_RDATA and EXT_RDATA SHALL hold their last value when not strobed.

Reset
REQ-035 RESET SHALL force state IDLE and set CPU_ACK, EXT_ACK, EXT_RVALID, EXT_DONE and BUSY to 0, CPU_RDATA and EXT_RDATA to 0, and the round-robin pointer to favour the CPU.
REQ-036 Reset mid-burst SHALL abort with no further beats and no EXT_DONE; memory contents are not cleared.

Verification
REQ-037 CPU write 0xA5 @0x0010, then read @0x0010 -> CPU_ACK 2 cycles after each request, CPU_RDATA=0xA5.
REQ-038 EXT write burst LEN=3 @0x0100 with data 1,2,3,4 -> 4 consecutive EXT_ACK, EXT_DONE 1 cycle later; read-back burst gives RVALID x4 with data 1,2,3,4.
REQ-039 EXT read LEN=1 @DEPTH-1 with DEPTH=256 -> beats at addresses 0xFF then 0x00.
REQ-040 CPU_REQ and EXT_REQ asserted together twice: ARB_MODE=0 -> CPU first then EXT; ARB_MODE=1 -> CPU both times with EXT starved while CPU_REQ stays high.
REQ-041 RESET asserted during the 2nd beat of a LEN=7 burst -> outputs 0 immediately, no EXT_DONE, earlier-written beat retained.
